uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter for the JPEB SoC. Accepts words from the memory-mapped I/O path into an internal FIFO and serialises them on a single `tx` line with configurable baud rate, data width, parity and stop bits. Back-to-back frames are sent with no idle gap, and full/empty/level status is exposed so the CPU can poll before writing.

---
 rtl/jpeb_uart_pkg.sv | 10 +
 rtl/sync_fifo.sv | 38 +++
 rtl/uart_tx_fifo.sv | 111 +++++++++++
 tb/tb_uart_tx_fifo.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/jpeb_uart_pkg.sv
// jpeb_uart_pkg: shared UART constants, FSM encoding and baud divisor rounding
package jpeb_uart_pkg;
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_e;
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO with combinational head, drop-on-full push and ignore-on-empty pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = wr_q - rd_q;
  assign full    = level == (AW + 1)'(DEPTH);
  assign empty   = wr_q == rd_q;
  assign head    = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= do_push ? wr_q + 1'b1 : wr_q;
      rd_q <= do_pop ? rd_q + 1'b1 : rd_q;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter with zero-gap back-to-back frames
module uart_tx_fifo
  import jpeb_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  if (DIV < 2) begin : g_div_chk
    $error("uart_tx_fifo: DIV must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_par_chk
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_chk
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, head;
  logic par_q, par_d, tx_q, tx_d, ovf_q, pop, tick, last_data, last_stop;
  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(wr_en), .push_data(wr_data), .pop(pop),
    .head(head), .full(full), .empty(empty), .level(level)
  );
  assign tick      = cnt_q == '0;
  assign last_data = bit_q == 4'(DATA_BITS - 1);
  assign last_stop = bit_q == 4'(STOP_BITS - 1);
  assign pop       = !empty && (state_q == IDLE || (state_q == STOP && tick && last_stop));
  assign busy      = state_q != IDLE;
  assign tx        = tx_q;
  assign overflow  = ovf_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? CW'(DIV - 1) : cnt_q - 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    case (state_q)
      IDLE:  cnt_d = cnt_q;
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA:  if (tick) begin
        shift_d = shift_q >> 1;
        bit_d   = last_data ? '0 : bit_q + 1'b1;
        state_d = !last_data ? DATA : (PARITY != PARITY_NONE) ? PAR : STOP;
      end
      PAR:   if (tick) begin
        state_d = STOP;
        bit_d   = '0;
      end
      STOP:  if (tick) begin
        bit_d   = last_stop ? '0 : bit_q + 1'b1;
        state_d = last_stop ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      cnt_d   = CW'(DIV - 1);
      bit_d   = '0;
      shift_d = head;
      par_d   = (^head) ^ (PARITY == PARITY_ODD);
    end
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : (state_d == PAR) ? par_d : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ovf_q   <= wr_en && full;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench comparing line waveforms against a frame-level model
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;
  logic wr_en = 1'b0, wr_en_p = 1'b0, wr_en_d = 1'b0;
  logic [7:0] wr_data = '0, wr_data_d = '0;
  logic [6:0] wr_data_p = '0;
  logic full, empty, overflow, busy, tx;
  logic [2:0] level;
  logic full_p, empty_p, overflow_p, busy_p, tx_p;
  logic [2:0] level_p;
  logic full_d, empty_d, overflow_d, busy_d, tx_d;
  logic [4:0] level_d;
  int total = 0;
  int bad = 0;
  int expq[$];
  logic txq[$], busyq[$], emptyq[$], txq_p[$], busyq_p[$], txq_d[$], busyq_d[$];
  logic [2:0] levelq[$];
  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(250_000), .DATA_BITS(8), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .busy(busy), .tx(tx));
  uart_tx_fifo #(.CLK_HZ(1_000_000), .BAUD(250_000), .DATA_BITS(7), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(2)) dut_p (
    .clk(clk), .reset(reset), .wr_en(wr_en_p), .wr_data(wr_data_p), .full(full_p), .empty(empty_p),
    .level(level_p), .overflow(overflow_p), .busy(busy_p), .tx(tx_p));
  uart_tx_fifo dut_d (
    .clk(clk), .reset(reset), .wr_en(wr_en_d), .wr_data(wr_data_d), .full(full_d), .empty(empty_d),
    .level(level_d), .overflow(overflow_d), .busy(busy_d), .tx(tx_d));
  always @(negedge clk) begin
    txq.push_back(tx);
    busyq.push_back(busy);
    levelq.push_back(level);
    emptyq.push_back(empty);
    txq_p.push_back(tx_p);
    busyq_p.push_back(busy_p);
    txq_d.push_back(tx_d);
    busyq_d.push_back(busy_d);
  end
  function automatic logic line_bit(input int word, input int nb, input int par, input int div, input int t);
    int b;
    b = t / div;
    if (b == 0) return 1'b0;
    if (b <= nb) return ((word >> (b - 1)) & 1) != 0;
    if (par != 0 && b == nb + 1) return ((($countones(word & ((1 << nb) - 1)) % 2) != 0) ^ (par == 2));
    return 1'b1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic scan(input int base, input int len, output int nbad, output int first_t, output int nbusy);
    logic e;
    int f;
    repeat (base + len - txq.size()) tick();
    nbad = 0;
    first_t = -1;
    nbusy = 0;
    for (int t = 0; t < len; t++) begin
      f = t / 40;
      e = (f < expq.size()) ? line_bit(expq[f], 8, 0, 4, t % 40) : 1'b1;
      if (txq[base + t] !== e) begin
        nbad++;
        if (first_t < 0) first_t = t;
      end
      if (busyq[base + t] === 1'b1) nbusy++;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", full); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    total++; if ({tx_p, busy_p, tx_d, busy_d} !== 4'b1010) begin bad++; $display("FAIL reset_others: got %b want 1010", {tx_p, busy_p, tx_d, busy_d}); end
  endtask
  task automatic test_single();
    int base, nbad, first_t, nbusy;
    expq = {32'hA5};
    put(8'hA5);
    total++; if ({level, empty, tx} !== {3'd1, 1'b0, 1'b1}) begin bad++; $display("FAIL single_write: got level=%0d empty=%b tx=%b want 1 0 1", level, empty, tx); end
    tick();
    base = txq.size();
    total++; if ({tx, busy, level, empty} !== {1'b0, 1'b1, 3'd0, 1'b1}) begin bad++; $display("FAIL single_start: got tx=%b busy=%b level=%0d empty=%b want 0 1 0 1", tx, busy, level, empty); end
    scan(base, 44, nbad, first_t, nbusy);
    total++; if (nbad !== 0) begin bad++; $display("FAIL single_line: got %0d bad cycles (first %0d) want 0", nbad, first_t); end
    total++; if (nbusy !== 40 || busyq[base + 40] !== 1'b0) begin bad++; $display("FAIL single_busy: got %0d busy cycles want 40", nbusy); end
  endtask
  task automatic test_back_to_back();
    int base, nbad, first_t, nbusy;
    expq = {32'h01, 32'h02, 32'h03};
    put(8'h01);
    total++; if (level !== 3'd1) begin bad++; $display("FAIL b2b_level0: got %0d want 1", level); end
    put(8'h02);
    base = txq.size();
    total++; if (level !== 3'd1 || tx !== 1'b0) begin bad++; $display("FAIL b2b_pushpop: got level=%0d tx=%b want 1 0", level, tx); end
    put(8'h03);
    total++; if (level !== 3'd2) begin bad++; $display("FAIL b2b_level2: got %0d want 2", level); end
    scan(base, 124, nbad, first_t, nbusy);
    total++; if (nbad !== 0) begin bad++; $display("FAIL b2b_line: got %0d bad cycles (first %0d) want 0", nbad, first_t); end
    total++; if (nbusy !== 120) begin bad++; $display("FAIL b2b_busy: got %0d busy cycles want 120", nbusy); end
    total++; if ({levelq[base + 40], levelq[base + 80], emptyq[base + 80]} !== {3'd1, 3'd0, 1'b1}) begin bad++; $display("FAIL b2b_levels: got %0d %0d empty=%b want 1 0 1", levelq[base + 40], levelq[base + 80], emptyq[base + 80]); end
  endtask
  task automatic test_overflow();
    int base, nbad, first_t, nbusy;
    logic [7:0] w[6];
    for (int i = 0; i < 6; i++) w[i] = 8'($urandom);
    expq = {};
    for (int i = 0; i < 5; i++) expq.push_back(int'(w[i]));
    put(w[0]);
    tick();
    base = txq.size();
    for (int i = 1; i < 5; i++) put(w[i]);
    total++; if ({full, level} !== {1'b1, 3'd4}) begin bad++; $display("FAIL ovf_full: got full=%b level=%0d want 1 4", full, level); end
    put(8'($urandom));
    total++; if ({overflow, level} !== {1'b1, 3'd4}) begin bad++; $display("FAIL ovf_pulse5: got ovf=%b level=%0d want 1 4", overflow, level); end
    tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    put(w[5]);
    total++; if ({overflow, full, level} !== {1'b1, 1'b1, 3'd4}) begin bad++; $display("FAIL ovf_pulse6: got ovf=%b full=%b level=%0d want 1 1 4", overflow, full, level); end
    scan(base, 204, nbad, first_t, nbusy);
    total++; if (nbad !== 0) begin bad++; $display("FAIL ovf_line: got %0d bad cycles (first %0d) want 0", nbad, first_t); end
    total++; if (nbusy !== 200) begin bad++; $display("FAIL ovf_busy: got %0d busy cycles want 200", nbusy); end
  endtask
  task automatic test_reset_mid();
    int base, b2, nbad, first_t, nbusy, lows;
    put(8'h00);
    tick();
    base = txq.size();
    put(8'h00);
    put(8'h00);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    total++; if ({tx, busy, level, empty, full} !== {1'b1, 1'b0, 3'd0, 1'b1, 1'b0}) begin bad++; $display("FAIL rst_mid: got tx=%b busy=%b level=%0d empty=%b full=%b want 1 0 0 1 0", tx, busy, level, empty, full); end
    reset = 1'b0;
    put(8'h3C);
    tick();
    b2 = txq.size();
    lows = 0;
    for (int i = base + 17; i < b2; i++) lows += (txq[i] !== 1'b1) ? 1 : 0;
    total++; if (lows !== 0) begin bad++; $display("FAIL rst_idle: got %0d non-idle cycles want 0", lows); end
    expq = {32'h3C};
    scan(b2, 44, nbad, first_t, nbusy);
    total++; if (nbad !== 0 || nbusy !== 40) begin bad++; $display("FAIL rst_resume: got %0d bad cycles %0d busy want 0 40", nbad, nbusy); end
  endtask
  task automatic test_random_bursts();
    int base, nbad, first_t, nbusy, k;
    logic [7:0] d;
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(1, 5);
      expq = {};
      base = 0;
      for (int j = 0; j < k; j++) begin
        d = 8'($urandom);
        expq.push_back(int'(d));
        put(d);
        if (j == 0) base = txq.size() + 1;
        repeat ($urandom_range(0, 2)) tick();
      end
      scan(base, 40 * k + 4, nbad, first_t, nbusy);
      total++; if (nbad !== 0) begin bad++; $display("FAIL burst%0d_line: got %0d bad cycles (first %0d) want 0", r, nbad, first_t); end
      total++; if (nbusy !== 40 * k || level !== 3'd0) begin bad++; $display("FAIL burst%0d_busy: got %0d busy level=%0d want %0d 0", r, nbusy, level, 40 * k); end
    end
  endtask
  task automatic test_parity();
    int base, nbad, nbusy;
    logic [6:0] w;
    for (int r = 0; r < 3; r++) begin
      w = (r == 0) ? 7'h55 : 7'($urandom_range(0, 127));
      wr_en_p = 1'b1;
      wr_data_p = w;
      tick();
      wr_en_p = 1'b0;
      tick();
      base = txq_p.size();
      repeat (48) tick();
      nbad = 0;
      nbusy = 0;
      for (int t = 0; t < 48; t++) begin
        if (txq_p[base + t] !== line_bit(int'(w), 7, 2, 4, t)) nbad++;
        if (busyq_p[base + t] === 1'b1) nbusy++;
      end
      total++; if (nbad !== 0 || nbusy !== 44) begin bad++; $display("FAIL par%0d_frame: got %0d bad cycles %0d busy want 0 44", r, nbad, nbusy); end
      if (r == 0) begin
        total++; if (txq_p[base + 33] !== 1'b1) begin bad++; $display("FAIL par_bit55: got %b want 1", txq_p[base + 33]); end
      end
    end
  endtask
  task automatic test_default();
    int base, nbad, nbusy;
    wr_en_d = 1'b1;
    wr_data_d = 8'h65;
    tick();
    wr_en_d = 1'b0;
    tick();
    base = txq_d.size();
    repeat (4344) tick();
    nbad = 0;
    nbusy = 0;
    for (int t = 0; t < 4344; t++) begin
      if (txq_d[base + t] !== line_bit(32'h65, 8, 0, 434, t)) nbad++;
      if (busyq_d[base + t] === 1'b1) nbusy++;
    end
    total++; if (nbad !== 0) begin bad++; $display("FAIL dflt_line: got %0d bad cycles want 0", nbad); end
    total++; if (nbusy !== 4340) begin bad++; $display("FAIL dflt_busy: got %0d busy cycles want 4340", nbusy); end
    total++; if ({txq_d[base + 433], txq_d[base + 434]} !== 2'b01) begin bad++; $display("FAIL dflt_edge: got %b want 01", {txq_d[base + 433], txq_d[base + 434]}); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    test_random_bursts();
    test_parity();
    test_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
